// File: rtl/buzzer_pkg.sv
// Shared types and default timing for the buzzer tone scheduler.
// State encoding doubles as the active_id output encoding.
package buzzer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLICK = 2'd1,
        ST_PASS  = 2'd2,
        ST_FAIL  = 2'd3
    } buzz_state_e;

    localparam logic [1:0] ID_NONE  = 2'd0;
    localparam logic [1:0] ID_CLICK = 2'd1;
    localparam logic [1:0] ID_PASS  = 2'd2;
    localparam logic [1:0] ID_FAIL  = 2'd3;

    localparam int unsigned DEF_CLICK_HALF  = 32'd50000;
    localparam int unsigned DEF_CLICK_LEN   = 32'd10000000;
    localparam int unsigned DEF_PASS_HALF   = 32'd25000;
    localparam int unsigned DEF_PASS_LEN    = 32'd30000000;
    localparam int unsigned DEF_FAIL_HALF   = 32'd100000;
    localparam int unsigned DEF_FAIL_LEN    = 32'd15000000;
    localparam int unsigned DEF_FAIL_GAP_LO = 32'd5000000;
    localparam int unsigned DEF_FAIL_GAP_HI = 32'd10000000;

    // Open interval test used for the silent window of the failure tone.
    function automatic logic in_window(input logic [31:0] cnt,
                                       input logic [31:0] lo,
                                       input logic [31:0] hi);
        return (cnt > lo) && (cnt < hi);
    endfunction

endpackage

// File: rtl/buzzer_sched_if.sv
// Request/status bundle between a tone requester and buzzer_sched.
interface buzzer_sched_if;
    logic       req_click;
    logic       req_pass;
    logic       req_fail;
    logic       buzzer;
    logic       busy;
    logic [1:0] active_id;

    modport master (output req_click, req_pass, req_fail,
                    input  buzzer, busy, active_id);
    modport slave  (input  req_click, req_pass, req_fail,
                    output buzzer, busy, active_id);
endinterface

// File: rtl/buzzer_sched_tone_gen.sv
// Half-period toggle counter; wave is the registered, masked square wave.
module tone_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        restart,
    input  logic        run,
    input  logic        mask,
    input  logic [31:0] half,
    output logic        wave
);
    logic [31:0] cnt_r;
    logic [31:0] cnt_next_s;
    logic        phase_r;
    logic        phase_next_s;

    // Next half counter and phase: restart starts high, idle parks low.
    always_comb begin
        cnt_next_s   = cnt_r;
        phase_next_s = phase_r;
        if (restart) begin
            cnt_next_s   = 32'd0;
            phase_next_s = 1'b1;
        end else if (run) begin
            if (cnt_r == half - 32'd1) begin
                cnt_next_s   = 32'd0;
                phase_next_s = ~phase_r;
            end else begin
                cnt_next_s   = cnt_r + 32'd1;
                phase_next_s = phase_r;
            end
        end else begin
            cnt_next_s   = 32'd0;
            phase_next_s = 1'b0;
        end
    end

    // Counter, phase and gated output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= 32'd0;
            phase_r <= 1'b0;
            wave    <= 1'b0;
        end else begin
            cnt_r   <= cnt_next_s;
            phase_r <= phase_next_s;
            wave    <= phase_next_s & ~mask;
        end
    end
endmodule

// File: rtl/buzzer_sched.sv
// Priority tone scheduler (FAIL > PASS > CLICK) driving a single buzzer.
// Optional BUZZER_SCHED_MUTE_EN adds a mute input that silences the buzzer only.
module buzzer_sched
    import buzzer_pkg::*;
#(
    parameter int unsigned CLICK_HALF  = DEF_CLICK_HALF,
    parameter int unsigned CLICK_LEN   = DEF_CLICK_LEN,
    parameter int unsigned PASS_HALF   = DEF_PASS_HALF,
    parameter int unsigned PASS_LEN    = DEF_PASS_LEN,
    parameter int unsigned FAIL_HALF   = DEF_FAIL_HALF,
    parameter int unsigned FAIL_LEN    = DEF_FAIL_LEN,
    parameter int unsigned FAIL_GAP_LO = DEF_FAIL_GAP_LO,
    parameter int unsigned FAIL_GAP_HI = DEF_FAIL_GAP_HI
) (
    input  logic          clk,
    input  logic          RSTn,
`ifdef BUZZER_SCHED_MUTE_EN
    input  logic          mute,
`endif
    buzzer_sched_if.slave bus
);
    buzz_state_e state_r, state_next_s;
    logic [31:0] dur_r, dur_next_s;
    logic        pend_r, pend_next_s;
    logic        busy_r;
    logic        restart_s, end_mask_s, ending_s, gap_s, run_s, mask_s;
    logic [31:0] half_s, len_end_s;

    // Per-state tone timing.
    always_comb begin
        case (state_r)
            ST_CLICK: begin half_s = CLICK_HALF; len_end_s = CLICK_LEN - 32'd1; end
            ST_PASS:  begin half_s = PASS_HALF;  len_end_s = PASS_LEN - 32'd1;  end
            ST_FAIL:  begin half_s = FAIL_HALF;  len_end_s = FAIL_LEN - 32'd1;  end
            default:  begin half_s = 32'd1;      len_end_s = 32'd0;             end
        endcase
    end

    assign ending_s = (state_r != ST_IDLE) && (dur_r == len_end_s);

    // Next-state: requests by priority, then natural end, then keep counting.
    always_comb begin
        state_next_s = state_r;
        dur_next_s   = dur_r + 32'd1;
        pend_next_s  = pend_r;
        restart_s    = 1'b0;
        end_mask_s   = 1'b0;
        if (bus.req_fail) begin
            state_next_s = ST_FAIL;
            dur_next_s   = 32'd0;
            restart_s    = 1'b1;
            if (bus.req_pass) begin
                pend_next_s = 1'b1;
            end else begin
                pend_next_s = pend_r;
            end
        end else if (bus.req_pass && (state_r == ST_FAIL) && !ending_s) begin
            pend_next_s = 1'b1;
        end else if (bus.req_pass) begin
            state_next_s = ST_PASS;
            dur_next_s   = 32'd0;
            restart_s    = 1'b1;
            pend_next_s  = 1'b0;
        end else if (bus.req_click && ((state_r == ST_IDLE) || (state_r == ST_CLICK) ||
                                       (ending_s && !pend_r))) begin
            state_next_s = ST_CLICK;
            dur_next_s   = 32'd0;
            restart_s    = 1'b1;
        end else if (ending_s) begin
            dur_next_s = 32'd0;
            if (pend_r) begin
                // Pending pass starts on the ending edge; that edge still drives 0.
                state_next_s = ST_PASS;
                restart_s    = 1'b1;
                pend_next_s  = 1'b0;
                end_mask_s   = 1'b1;
            end else begin
                state_next_s = ST_IDLE;
            end
        end else if (state_r == ST_IDLE) begin
            dur_next_s = 32'd0;
        end else begin
            dur_next_s = dur_r + 32'd1;
        end
    end

    assign run_s = (state_next_s != ST_IDLE) && !restart_s;
    assign gap_s = (state_next_s == ST_FAIL) && in_window(dur_next_s, FAIL_GAP_LO, FAIL_GAP_HI);
`ifdef BUZZER_SCHED_MUTE_EN
    assign mask_s = (state_next_s == ST_IDLE) | end_mask_s | gap_s | mute;
`else
    assign mask_s = (state_next_s == ST_IDLE) | end_mask_s | gap_s;
`endif

    // State, duration counter, pending flag and busy register.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state_r <= ST_IDLE;
            dur_r   <= 32'd0;
            pend_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            dur_r   <= dur_next_s;
            pend_r  <= pend_next_s;
            busy_r  <= (state_next_s != ST_IDLE);
        end
    end

    tone_gen u_tone_gen (
        .clk     (clk),
        .rst_n   (RSTn),
        .restart (restart_s),
        .run     (run_s),
        .mask    (mask_s),
        .half    (half_s),
        .wave    (bus.buzzer)
    );

    assign bus.busy      = busy_r;
    assign bus.active_id = state_r;
endmodule

// File: tb/tb_buzzer_sched.sv
// Directed self-checking bench for buzzer_sched with short tone timings.
module tb_buzzer_sched;
    logic clk;
    logic rst_n;
    logic mute;
    int   n_cmp;
    int   n_err;

    buzzer_sched_if bus ();

    buzzer_sched #(
        .CLICK_HALF(4), .CLICK_LEN(32),
        .PASS_HALF(2),  .PASS_LEN(48),
        .FAIL_HALF(8),  .FAIL_LEN(64),
        .FAIL_GAP_LO(16), .FAIL_GAP_HI(32)
    ) dut (
        .clk  (clk),
        .RSTn (rst_n),
`ifdef BUZZER_SCHED_MUTE_EN
        .mute (mute),
`endif
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".idle_buzzer"}, {31'd0, bus.buzzer}, 32'd0);
        chk({tag, ".idle_busy"},   {31'd0, bus.busy},   32'd0);
        chk({tag, ".idle_id"},     {30'd0, bus.active_id}, 32'd0);
    endtask

    function automatic logic exp_wave(input int k, input int half, input bit fail_gap,
                                      input bit first_low, input bit muted);
        logic b;
        b = ((k / half) % 2) == 0;
        if (fail_gap && (k > 16) && (k < 32)) b = 1'b0;
        if (first_low && (k == 0)) b = 1'b0;
        if (muted) b = 1'b0;
        return b;
    endfunction

    // Checks a full tone from its entry cycle (k=0) through its last cycle.
    task automatic play(input string tag, input logic [1:0] id, input int half, input int len,
                        input bit fail_gap, input bit first_low, input bit muted);
        for (int k = 0; k < len; k++) begin
            chk({tag, ".buzzer"}, {31'd0, bus.buzzer},
                {31'd0, exp_wave(k, half, fail_gap, first_low, muted)});
            chk({tag, ".busy"}, {31'd0, bus.busy}, 32'd1);
            chk({tag, ".id"}, {30'd0, bus.active_id}, {30'd0, id});
            step();
        end
    endtask

    task automatic pulse(input bit c, input bit p, input bit f);
        bus.req_click = c;
        bus.req_pass  = p;
        bus.req_fail  = f;
        step();
        bus.req_click = 1'b0;
        bus.req_pass  = 1'b0;
        bus.req_fail  = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        mute  = 1'b0;
        rst_n = 1'b0;
        bus.req_click = 1'b0;
        bus.req_pass  = 1'b0;
        bus.req_fail  = 1'b0;
        repeat (3) step();
        chk_idle("reset");
        rst_n = 1'b1;
        step();
        chk_idle("post_reset");

        // Click alone: 4-cycle half period, 32-cycle duration.
        pulse(1'b1, 1'b0, 1'b0);
        play("click", 2'd1, 4, 32, 1'b0, 1'b0, 1'b0);
        chk_idle("click_end");

        // Fail alone: 8-cycle half period with silent window 17..31.
        pulse(1'b0, 1'b0, 1'b1);
        play("fail", 2'd3, 8, 64, 1'b1, 1'b0, 1'b0);
        chk_idle("fail_end");

        // Click retrigger at count 6 restarts the tone high.
        pulse(1'b1, 1'b0, 1'b0);
        repeat (6) step();
        chk("retrig.pre_buzzer", {31'd0, bus.buzzer}, 32'd0);
        pulse(1'b1, 1'b0, 1'b0);
        play("retrig", 2'd1, 4, 32, 1'b0, 1'b0, 1'b0);
        chk_idle("retrig_end");

        // Fail preempts click 10 cycles in; click never resumes.
        pulse(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 9; k++) begin
            chk("preempt.click_id", {30'd0, bus.active_id}, 32'd1);
            step();
        end
        chk("preempt.click_id9", {30'd0, bus.active_id}, 32'd1);
        pulse(1'b0, 1'b0, 1'b1);
        play("preempt_fail", 2'd3, 8, 64, 1'b1, 1'b0, 1'b0);
        chk_idle("preempt_end");

        // Click during pass is dropped.
        pulse(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 48; k++) begin
            chk("pass_drop.id", {30'd0, bus.active_id}, 32'd2);
            chk("pass_drop.buzzer", {31'd0, bus.buzzer}, {31'd0, exp_wave(k, 2, 1'b0, 1'b0, 1'b0)});
            bus.req_click = (k == 3);
            step();
        end
        bus.req_click = 1'b0;
        chk_idle("pass_drop_end");

        // Simultaneous requests: fail, then pending pass, click dropped.
        pulse(1'b1, 1'b1, 1'b1);
        play("simul_fail", 2'd3, 8, 64, 1'b1, 1'b0, 1'b0);
        play("simul_pass", 2'd2, 2, 48, 1'b0, 1'b1, 1'b0);
        chk_idle("simul_end");
        repeat (4) step();
        chk_idle("simul_no_click");

        // Asynchronous reset in the middle of a pass tone.
        pulse(1'b0, 1'b1, 1'b0);
        repeat (20) step();
        chk("mid_pass.buzzer", {31'd0, bus.buzzer}, 32'd1);
        #3;
        rst_n = 1'b0;
        bus.req_click = 1'b1;
        #1;
        chk_idle("async_reset");
        repeat (3) step();
        chk_idle("held_reset");
        bus.req_click = 1'b0;
        rst_n = 1'b1;
        repeat (5) step();
        chk_idle("after_release");

`ifdef BUZZER_SCHED_MUTE_EN
        // Mute silences the click while the scheduler still runs it.
        mute = 1'b1;
        pulse(1'b1, 1'b0, 1'b0);
        play("mute", 2'd1, 4, 32, 1'b0, 1'b0, 1'b1);
        chk_idle("mute_end");
        mute = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
